// File: rtl/fm_wm_if.sv
// Bundles the scheduler's control, memory-read, operand-load and result
// handshake signals. slave = the scheduler, master = GCN control plus the
// memories and result buffer around it.
interface fm_wm_if #(
  parameter int ROW_AW         = 3,
  parameter int COL_AW         = 2,
  parameter int DOT_PROD_WIDTH = 16
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      wt_rd_en;
  logic [COL_AW-1:0]         wt_rd_addr;
  logic                      wt_load;
  logic                      ft_rd_en;
  logic [ROW_AW-1:0]         ft_rd_addr;
  logic                      ft_load;
  logic [DOT_PROD_WIDTH-1:0] fm_wm_in;
  logic                      res_valid;
  logic                      res_ready;
  logic [DOT_PROD_WIDTH-1:0] res_data;
  logic [ROW_AW-1:0]         res_row;
  logic [COL_AW-1:0]         res_col;

  modport slave (
    input  start, fm_wm_in, res_ready,
    output busy, done, wt_rd_en, wt_rd_addr, wt_load,
           ft_rd_en, ft_rd_addr, ft_load,
           res_valid, res_data, res_row, res_col
  );

  modport master (
    output start, fm_wm_in, res_ready,
    input  busy, done, wt_rd_en, wt_rd_addr, wt_load,
           ft_rd_en, ft_rd_addr, ft_load,
           res_valid, res_data, res_row, res_col
  );
endinterface

// File: rtl/fm_wm_scheduler.sv
// Feature x weight dot-product sequencer. Walks every (row, col) pair in
// column-major order, fetching each weight column once and reusing it for
// all feature rows, and hands each captured dot product to the result buffer.
//
// state | meaning
// IDLE  | waiting for start; counters cleared on start
// RD_W  | weight read issued for column col
// LD_W  | weight data valid, weight register strobed
// RD_F  | feature read issued for row row
// LD_F  | feature data valid, feature register strobed
// MAC   | dot product settled, captured with its (row, col)
// WR    | result offered, held until res_ready
// DONE  | one-cycle completion pulse
module fm_wm_scheduler #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int FEATURE_COLS   = 96,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ROW_AW         = $clog2(FEATURE_ROWS),
  parameter int COL_AW         = $clog2(WEIGHT_COLS)
) (
  input logic   clk,
  input logic   rst_n,
  fm_wm_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_W = 3'd1;
  localparam logic [2:0] S_LD_W = 3'd2;
  localparam logic [2:0] S_RD_F = 3'd3;
  localparam logic [2:0] S_LD_F = 3'd4;
  localparam logic [2:0] S_MAC  = 3'd5;
  localparam logic [2:0] S_WR   = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(FEATURE_ROWS - 1);
  localparam logic [COL_AW-1:0] COL_LAST = COL_AW'(WEIGHT_COLS - 1);

  // The dot-product length only sizes the multiplier; nothing here counts it.
  if (FEATURE_COLS < 1) begin : g_no_feature_cols
  end

  logic [2:0]                state_q, state_d;
  logic [ROW_AW-1:0]         row_q;
  logic [COL_AW-1:0]         col_q;
  logic [DOT_PROD_WIDTH-1:0] res_data_q;
  logic [ROW_AW-1:0]         res_row_q;
  logic [COL_AW-1:0]         res_col_q;
  logic                      row_last, col_last;

  assign row_last = (row_q == ROW_LAST);
  assign col_last = (col_q == COL_LAST);

  // Next-state logic for the fetch / capture / handshake sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_RD_W;
      S_RD_W: state_d = S_LD_W;
      S_LD_W: state_d = S_RD_F;
      S_RD_F: state_d = S_LD_F;
      S_LD_F: state_d = S_MAC;
      S_MAC:  state_d = S_WR;
      S_WR: begin
        if (bus.res_ready) begin
          if (!row_last)      state_d = S_RD_F;
          else if (!col_last) state_d = S_RD_W;
          else                state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any run without producing done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Row/column iteration counters, advanced only on result acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      row_q <= '0;
      col_q <= '0;
    end else if (state_q == S_WR && bus.res_ready) begin
      if (!row_last) begin
        row_q <= row_q + ROW_AW'(1);
      end else if (!col_last) begin
        row_q <= '0;
        col_q <= col_q + COL_AW'(1);
      end
    end
  end

  // Result capture in MAC; held untouched while the buffer stalls in WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q <= '0;
      res_row_q  <= '0;
      res_col_q  <= '0;
    end else if (state_q == S_MAC) begin
      res_data_q <= bus.fm_wm_in;
      res_row_q  <= row_q;
      res_col_q  <= col_q;
    end
  end

  // Outputs are pure decodes of registered state, so start and res_ready
  // never reach an output combinationally.
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.wt_rd_en   = (state_q == S_RD_W);
  assign bus.wt_load    = (state_q == S_LD_W);
  assign bus.ft_rd_en   = (state_q == S_RD_F);
  assign bus.ft_load    = (state_q == S_LD_F);
  assign bus.res_valid  = (state_q == S_WR);
  assign bus.wt_rd_addr = col_q;
  assign bus.ft_rd_addr = row_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_row    = res_row_q;
  assign bus.res_col    = res_col_q;

endmodule

// File: doc/fm_wm_scheduler.md
# fm_wm_scheduler

Sequencer for the feature × weight dot-product datapath of the GCN combination stage. On a `start` pulse it walks every (feature row, weight column) pair. For each pair it fetches the weight column and the feature row from their memories, strobes the datapath operand registers, captures the combinational 96-term dot product `fm_wm_in`, and hands the result to the output buffer over a valid/ready handshake. The block sits between the top-level GCN control, the weight/feature SRAMs, the `Vector_Multiplier` operand registers, and the FM×WM result buffer.

## Interface
- `FEATURE_ROWS`, 6, number of feature-matrix rows (nodes)
- `WEIGHT_COLS`, 3, number of weight-matrix columns (output features)
- `FEATURE_COLS`, 96, dot-product length (informational; no counter depends on it)
- `DOT_PROD_WIDTH`, 16, width of `fm_wm_in` and `res_data`
- `ROW_AW`, `$clog2(FEATURE_ROWS)`, feature row address width
- `COL_AW`, `$clog2(WEIGHT_COLS)`, weight column address width

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: single-cycle request; sampled only in IDLE
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse after the last result is accepted
- `wt_rd_en` out 1: weight memory read enable
- `wt_rd_addr` out COL_AW: weight column address
- `wt_load` out 1: capture strobe for the weight-column register
- `ft_rd_en` out 1: feature memory read enable
- `ft_rd_addr` out ROW_AW: feature row address
- `ft_load` out 1: capture strobe for the feature-row register
- `fm_wm_in` in DOT_PROD_WIDTH: dot product from the multiplier
- `res_valid` out 1: result available
- `res_ready` in 1: output buffer accepts the result
- `res_data` out DOT_PROD_WIDTH: registered dot product
- `res_row` out ROW_AW: row index of the result
- `res_col` out COL_AW: column index of the result

## Operation
- Memories have 1-cycle read latency: data addressed in cycle N is valid in cycle N+1, when the matching `*_load` is high.
- Iteration order: column-major. The outer loop runs over `col` 0..WEIGHT_COLS-1 and the inner loop over `row` 0..FEATURE_ROWS-1. Each weight column is fetched once and reused for all rows.
- FSM states: IDLE, RD_W, LD_W, RD_F, LD_F, MAC, WR, DONE.
  - IDLE: if `start`, clear `row` and `col`, then go to RD_W. Otherwise stay.
  - RD_W: `wt_rd_en`=1, `wt_rd_addr`=`col`. Go to LD_W.
  - LD_W: `wt_load`=1. Go to RD_F.
  - RD_F: `ft_rd_en`=1, `ft_rd_addr`=`row`. Go to LD_F.
  - LD_F: `ft_load`=1. Go to MAC.
  - MAC: `fm_wm_in` is settled. Register it into `res_data`, with `res_row`=`row` and `res_col`=`col`. Go to WR.
  - WR: `res_valid`=1. Hold until `res_ready`. On acceptance:
    - if `row` < FEATURE_ROWS-1: increment `row`, go to RD_F;
    - else if `col` < WEIGHT_COLS-1: set `row`=0, increment `col`, go to RD_W;
    - else go to DONE.
  - DONE: `done`=1 for one cycle. Go to IDLE.
- Address outputs are driven from the counters and are only meaningful while their enable is high.
- Arithmetic: `res_data` is a straight register of `fm_wm_in` with no truncation or saturation. Overflow wrap is owned by the multiplier.
- `start` outside IDLE is ignored; it is neither queued nor used to restart.
- While waiting in WR, `res_data`, `res_row` and `res_col` are held stable, and no memory reads are issued.
- `rst_n` low at any time, including mid-sequence:
  - the FSM goes to IDLE and counters clear to 0;
  - all outputs go to 0 immediately (asynchronously);
  - no `done` is produced for the aborted run;
  - the sequence restarts only on a new `start`.

## Timing
- Reset values: `busy`, `done`, `wt_rd_en`, `wt_load`, `ft_rd_en`, `ft_load` and `res_valid` are 0. `wt_rd_addr`, `ft_rd_addr`, `res_data`, `res_row` and `res_col` are 0.
- All outputs are registered state decodes or registers. There is no combinational path from `res_ready` or `start` to any output.
- `start` sampled high at edge 0 places RD_W in cycle 1.
- Per column: 2 cycles (RD_W, LD_W), then 4 cycles per row (RD_F, LD_F, MAC, WR) when `res_ready` is held high.
- Full run with `res_ready`=1: 3 × (2 + 6×4) = 78 cycles (cycles 1–78). `done` is in cycle 79 and `busy` falls in cycle 80.
- Each cycle `res_ready` is low in WR adds exactly one cycle to the total latency.
- `res_valid` must not fall until a cycle in which `res_ready` is high.
- Back-to-back runs: `start` in the cycle after DONE (i.e. in IDLE) begins a new run with no extra gap.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, then release with `start`=0 → all outputs stay 0 and `busy`=0 for 10 cycles.
- Nominal run:
  - stimulus: `fm_wm_in` driven as 100·row + col by a model, `res_ready`=1, one `start` pulse;
  - response: 18 results accepted in the order (row, col) = (0,0), (1,0) … (5,0), (0,1) … (5,2), with matching `res_data`;
  - response: `wt_rd_en` pulses exactly 3 times and `ft_rd_en` exactly 18 times;
  - response: `done` is in cycle 79.
- Backpressure:
  - stimulus: `res_ready` low for 5 cycles on the result (2,1), with `fm_wm_in` changing during the stall;
  - response: `res_data`, `res_row` and `res_col` stay stable, with no memory reads during the stall;
  - response: `done` is in cycle 84.
- Ignored start: pulse `start` in cycles 10 and 50 during a run → result order and the `done` cycle are unchanged, and there is exactly one `done`.
- Mid-run reset: assert `rst_n`=0 asynchronously in cycle 40 → all outputs are 0 before the next edge and no `done` follows. A new `start` then reproduces the full 78-cycle sequence from (0,0).
- Back-to-back: `start` in the cycle after `done` → a second identical 18-result run, with `done` 79 cycles after the second `start`.
